// File: rtl/qbit_collector.sv
// qbit_collector: shifts 1 or 2 result bits per beat into a WORD_LENGTH-bit
// word, counts them, and presents the finished word with a valid/ready handshake.
// Optional feature macro: QCOLLECT_CORR_EN (corr on the completing beat loads word-1).
module qbit_collector #(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned SHIFT_LR    = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               bit_valid,
    input  logic [1:0]                         bits,
    input  logic                               snum,
    input  logic                               corr,
    input  logic                               out_ready,
    output logic [WORD_LENGTH-1:0]             Q,
    output logic                               q_valid,
    output logic                               busy,
    output logic                               err,
    output logic [$clog2(WORD_LENGTH+1)-1:0]   count
);

    localparam int unsigned W  = WORD_LENGTH;
    localparam int unsigned CW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [W-1:0]    q_n;
    logic [CW-1:0]   count_n;
    logic            err_n;
    logic [CW-1:0]   remaining;
    logic            take_two;
    logic            trunc;
    logic            bit_one;

`ifndef QCOLLECT_CORR_EN
    logic unused_corr;
    assign unused_corr = corr;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next datapath values
    always_comb begin
        state_n   = state;
        q_n       = Q;
        count_n   = count;
        err_n     = err;
        remaining = CW'(W) - count;
        take_two  = 1'b0;
        trunc     = 1'b0;
        bit_one   = 1'b0;

        if (start) begin
            state_n = COLLECT;
            q_n     = '0;
            count_n = '0;
            err_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                COLLECT: begin
                    if (bit_valid) begin
                        take_two = snum && (remaining >= CW'(2));
                        trunc    = snum && !take_two;
                        // On a truncated pair only the earlier bit of the stream is kept
                        if (SHIFT_LR == 0) begin
                            bit_one = snum ? bits[1] : bits[0];
                        end else begin
                            bit_one = bits[0];
                        end
                        if (take_two) begin
                            if (SHIFT_LR == 0) begin
                                q_n = (Q << 2) | W'(bits);
                            end else begin
                                q_n = (Q >> 2) | (W'(bits) << (W - 2));
                            end
                            count_n = count + CW'(2);
                        end else begin
                            if (SHIFT_LR == 0) begin
                                q_n = (Q << 1) | W'(bit_one);
                            end else begin
                                q_n = (Q >> 1) | (W'(bit_one) << (W - 1));
                            end
                            count_n = count + CW'(1);
                        end
                        if (trunc) begin
                            err_n = 1'b1;
                        end
                        if (count_n == CW'(W)) begin
                            state_n = DONE;
`ifdef QCOLLECT_CORR_EN
                            if (corr) begin
                                q_n = q_n - W'(1);
                            end
`endif
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Registered word, count, error and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q       <= '0;
            count   <= '0;
            err     <= 1'b0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            Q       <= q_n;
            count   <= count_n;
            err     <= err_n;
            q_valid <= (state_n == DONE);
            busy    <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_qbit_collector.sv
// Bench for qbit_collector: three instances (W=8 left, W=8 right, W=5 left)
// share one input stream; a bit-stream model predicts each word into a
// scoreboard that a negedge monitor drains when q_valid rises.
`timescale 1ns/1ps
module tb_qbit_collector;

    localparam int NDUT = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       bit_valid;
    logic [1:0] bits;
    logic       snum;
    logic       corr;
    logic       out_ready;

    logic [7:0] q0, q1;
    logic [4:0] q2;
    logic       v0, v1, v2;
    logic       b0, b1, b2;
    logic       e0, e1, e2;
    logic [3:0] c0, c1;
    logic [2:0] c2;

    qbit_collector #(.WORD_LENGTH(8), .SHIFT_LR(0)) dut_l8 (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .bits(bits),
        .snum(snum), .corr(corr), .out_ready(out_ready),
        .Q(q0), .q_valid(v0), .busy(b0), .err(e0), .count(c0));

    qbit_collector #(.WORD_LENGTH(8), .SHIFT_LR(1)) dut_r8 (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .bits(bits),
        .snum(snum), .corr(corr), .out_ready(out_ready),
        .Q(q1), .q_valid(v1), .busy(b1), .err(e1), .count(c1));

    qbit_collector #(.WORD_LENGTH(5), .SHIFT_LR(0)) dut_l5 (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .bits(bits),
        .snum(snum), .corr(corr), .out_ready(out_ready),
        .Q(q2), .q_valid(v2), .busy(b2), .err(e2), .count(c2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 word held
    int          m_word  [NDUT];
    int          m_cnt   [NDUT];
    int          m_phase [NDUT];
    int          m_err   [NDUT];
    int unsigned exp_q   [NDUT][$];
    logic        prev_v  [NDUT];

    function automatic int wlen(input int d);
        return (d == 2) ? 5 : 8;
    endfunction

    function automatic int rdir(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int dut_q(input int d);
        case (d)
            0: return int'(q0);
            1: return int'(q1);
            default: return int'(q2);
        endcase
    endfunction

    function automatic int dut_v(input int d);
        case (d)
            0: return int'(v0);
            1: return int'(v1);
            default: return int'(v2);
        endcase
    endfunction

    function automatic int dut_busy(input int d);
        case (d)
            0: return int'(b0);
            1: return int'(b1);
            default: return int'(b2);
        endcase
    endfunction

    function automatic int dut_err(input int d);
        case (d)
            0: return int'(e0);
            1: return int'(e1);
            default: return int'(e2);
        endcase
    endfunction

    function automatic int dut_cnt(input int d);
        case (d)
            0: return int'(c0);
            1: return int'(c1);
            default: return int'(c2);
        endcase
    endfunction

    task automatic check(input string name, input int d, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_word[d]  = 0;
            m_cnt[d]   = 0;
            m_phase[d] = 0;
            m_err[d]   = 0;
            exp_q[d].delete();
        end
    endtask

    // Apply one clock edge of the shared inputs to every model instance
    task automatic model_step();
        int s [2];
        int n;
        if (reset) return;
        for (int d = 0; d < NDUT; d++) begin
            if (start) begin
                m_word[d]  = 0;
                m_cnt[d]   = 0;
                m_err[d]   = 0;
                m_phase[d] = 1;
            end else if (m_phase[d] == 1 && bit_valid) begin
                if (!snum) begin
                    n = 1;
                    s[0] = int'(bits[0]);
                end else begin
                    n = 2;
                    if (rdir(d) == 0) begin
                        s[0] = int'(bits[1]);
                        s[1] = int'(bits[0]);
                    end else begin
                        s[0] = int'(bits[0]);
                        s[1] = int'(bits[1]);
                    end
                end
                for (int k = 0; k < n; k++) begin
                    if (m_cnt[d] < wlen(d)) begin
                        if (rdir(d) == 0) m_word[d] = m_word[d] * 2 + s[k];
                        else              m_word[d] = m_word[d] + (s[k] << m_cnt[d]);
                        m_cnt[d]++;
                    end else begin
                        m_err[d] = 1;
                    end
                end
                if (m_cnt[d] == wlen(d)) begin
`ifdef QCOLLECT_CORR_EN
                    if (corr) m_word[d] = (m_word[d] - 1) & ((1 << wlen(d)) - 1);
`endif
                    m_phase[d] = 2;
                    exp_q[d].push_back(unsigned'(m_word[d] | (m_err[d] << 16)));
                end
            end else if (m_phase[d] == 2 && out_ready) begin
                m_phase[d] = 0;
            end
        end
    endtask

    // Monitor: per-cycle status against the model, words against the scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            int unsigned e;
            check("count", d, dut_cnt(d), m_cnt[d]);
            check("busy", d, dut_busy(d), (m_phase[d] != 0) ? 1 : 0);
            check("q_valid", d, dut_v(d), (m_phase[d] == 2) ? 1 : 0);
            check("err", d, dut_err(d), m_err[d]);
            if (dut_v(d) != 0 && !prev_v[d]) begin
                if (exp_q[d].size() == 0) begin
                    check("sb_unexpected_word", d, 1, 0);
                end else begin
                    e = exp_q[d].pop_front();
                    check("sb_word", d, dut_q(d), int'(e & 32'hFFFF));
                    check("sb_err", d, dut_err(d), int'(e >> 16));
                end
            end
            prev_v[d] <= (dut_v(d) != 0);
        end
    end

    task automatic drive(input logic st, input logic bv, input logic [1:0] b,
                         input logic sn, input logic cr, input logic rdy);
        start     = st;
        bit_valid = bv;
        bits      = b;
        snum      = sn;
        corr      = cr;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting mid-cycle
    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("rst_q", d, dut_q(d), 0);
            check("rst_count", d, dut_cnt(d), 0);
            check("rst_busy", d, dut_busy(d), 0);
            check("rst_valid", d, dut_v(d), 0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) prev_v[d] = 1'b0;
        reset = 1'b1;
        start = 1'b0; bit_valid = 1'b0; bits = 2'b00; snum = 1'b0; corr = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        for (int d = 0; d < NDUT; d++) begin
            check("init_q", d, dut_q(d), 0);
            check("init_err", d, dut_err(d), 0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Left-shift pair beats 10,11,01,00 -> 0xB4
        drive(1, 0, 2'b00, 0, 0, 0);
        drive(0, 1, 2'b10, 1, 0, 0);
        drive(0, 1, 2'b11, 1, 0, 0);
        drive(0, 1, 2'b01, 1, 0, 0);
        check("pre_done_valid", 0, dut_v(0), 0);
        drive(0, 1, 2'b00, 1, 0, 0);
        check("dir_l8_q", 0, dut_q(0), 8'hB4);
        check("dir_l8_valid", 0, dut_v(0), 1);
        check("dir_l8_count", 0, dut_cnt(0), 8);
        check("dir_l8_err", 0, dut_err(0), 0);
        drive(0, 0, 2'b00, 0, 0, 1);

        // Right-shift single beats 1,0,1,1,0,0,0,0 -> 0x0D
        drive(1, 0, 2'b00, 0, 0, 0);
        drive(0, 1, 2'b01, 0, 0, 0);
        drive(0, 1, 2'b00, 0, 0, 0);
        drive(0, 1, 2'b01, 0, 0, 0);
        drive(0, 1, 2'b01, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 2'b10, 0, 0, 0);
        check("dir_r8_q", 1, dut_q(1), 8'h0D);
        check("dir_r8_valid", 1, dut_v(1), 1);
        drive(0, 0, 2'b00, 0, 0, 1);

`ifdef QCOLLECT_CORR_EN
        drive(1, 0, 2'b00, 0, 0, 0);
        drive(0, 1, 2'b10, 1, 0, 0);
        drive(0, 1, 2'b11, 1, 0, 0);
        drive(0, 1, 2'b01, 1, 0, 0);
        drive(0, 1, 2'b00, 1, 1, 0);
        check("corr_b3", 0, dut_q(0), 8'hB3);
        drive(1, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 2'b00, 1, 0, 0);
        drive(0, 1, 2'b00, 1, 1, 0);
        check("corr_wrap", 0, dut_q(0), 8'hFF);
        drive(0, 0, 2'b00, 0, 0, 1);
`endif

        // W=5 truncated pair: 11,01,10 -> 11011, err
        drive(1, 0, 2'b00, 0, 0, 0);
        drive(0, 1, 2'b11, 1, 0, 0);
        drive(0, 1, 2'b01, 1, 0, 0);
        drive(0, 1, 2'b10, 1, 0, 0);
        check("trunc_q", 2, dut_q(2), 5'b11011);
        check("trunc_err", 2, dut_err(2), 1);
        check("trunc_count", 2, dut_cnt(2), 5);

        // Backpressure on the finished W=5 word
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'($urandom), 1'($urandom), 0, 0);
            check("bp_q", 2, dut_q(2), 5'b11011);
            check("bp_valid", 2, dut_v(2), 1);
        end
        drive(0, 0, 2'b00, 0, 0, 1);
        check("bp_release_valid", 2, dut_v(2), 0);
        check("bp_release_busy", 2, dut_busy(2), 0);
        check("bp_retain_q", 2, dut_q(2), 5'b11011);

        // Reset mid-word, then start beats a simultaneous beat
        drive(1, 0, 2'b00, 0, 0, 0);
        drive(0, 1, 2'b11, 1, 0, 0);
        drive(0, 1, 2'b01, 1, 0, 0);
        check("mid_count", 0, dut_cnt(0), 4);
        do_reset();
        drive(1, 1, 2'b11, 1, 0, 0);
        check("start_drop_count", 0, dut_cnt(0), 0);
        check("start_drop_busy", 0, dut_busy(0), 1);
        check("start_drop_q", 0, dut_q(0), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            drive(($urandom_range(0, 99) < 3) || (i == 0),
                  ($urandom_range(0, 99) < 75),
                  2'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < 40));
        end
        drive(0, 0, 2'b00, 0, 0, 1);
        drive(0, 0, 2'b00, 0, 0, 1);
        for (int d = 0; d < NDUT; d++) check("sb_leftover", d, exp_q[d].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
